// File: rtl/fp_align_add_pkg.sv
// Shared field widths and the unpacked-operand record for the single-precision
// align/add front end.
package fp_align_add_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int MANT_W = MAN_W + 1;
  localparam int RAW_W  = 25;
  localparam int FP_W   = 1 + EXP_W + MAN_W;
  localparam int BIAS   = 127;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exponent;
    logic [MANT_W-1:0] mantissa;
  } unpacked_t;

endpackage

// File: rtl/fp_align_add_unpack.sv
// Field split of one IEEE-754 single operand with hidden-bit insertion;
// denormals are flushed to zero.
module fp_unpack
  import fp_align_add_pkg::*;
(
  input  logic [FP_W-1:0] op,
  input  logic            flip_sign,
  output unpacked_t       unp
);

  logic hidden;

  always_comb begin
    hidden       = |op[FP_W-2:MAN_W];
    unp.sign     = op[FP_W-1] ^ flip_sign;
    unp.exponent = op[FP_W-2:MAN_W];
    unp.mantissa = hidden ? {1'b1, op[MAN_W-1:0]} : '0;
  end

endmodule

// File: rtl/fp_align_add.sv
// Three-stage align/add front end: S1 unpack/compare/swap, S2 align, S3 add or
// subtract. Output is unnormalized and feeds the post-correction normalizer.
module fp_align_add
  import fp_align_add_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FP_W-1:0]  op_a,
  input  logic [FP_W-1:0]  op_b,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             raw_sign,
  output logic [EXP_W-1:0] raw_exponent,
  output logic [RAW_W-1:0] raw_mantissa
);

  unpacked_t ua, ub;

  fp_unpack u_unpack_a (.op(op_a), .flip_sign(1'b0),   .unp(ua));
  fp_unpack u_unpack_b (.op(op_b), .flip_sign(op_sub), .unp(ub));

  logic stall;

  logic              s1_valid_q,     s1_valid_d;
  unpacked_t         s1_big_q,       s1_big_d;
  logic [EXP_W-1:0]  s1_small_exp_q, s1_small_exp_d;
  logic [MANT_W-1:0] s1_small_man_q, s1_small_man_d;
  logic              s1_eff_sub_q,   s1_eff_sub_d;

  logic              s2_valid_q,     s2_valid_d;
  logic              s2_sign_q,      s2_sign_d;
  logic [EXP_W-1:0]  s2_exp_q,       s2_exp_d;
  logic [MANT_W-1:0] s2_big_man_q,   s2_big_man_d;
  logic [MANT_W-1:0] s2_small_man_q, s2_small_man_d;
  logic              s2_eff_sub_q,   s2_eff_sub_d;

  logic              out_valid_q,    out_valid_d;
  logic              raw_sign_q,     raw_sign_d;
  logic [EXP_W-1:0]  raw_exp_q,      raw_exp_d;
  logic [RAW_W-1:0]  raw_man_q,      raw_man_d;

  logic              a_is_big;
  logic [EXP_W-1:0]  shamt;
  logic [MANT_W-1:0] small_aligned;

  assign stall        = out_valid_q && !out_ready;
  assign in_ready     = !stall;
  assign out_valid    = out_valid_q;
  assign raw_sign     = raw_sign_q;
  assign raw_exponent = raw_exp_q;
  assign raw_mantissa = raw_man_q;

  always_comb begin
    a_is_big      = {ua.exponent, ua.mantissa} >= {ub.exponent, ub.mantissa};
    shamt         = s1_big_q.exponent - s1_small_exp_q;
    small_aligned = (shamt >= EXP_W'(MANT_W)) ? '0 : (s1_small_man_q >> shamt);

    s1_valid_d     = s1_valid_q;
    s1_big_d       = s1_big_q;
    s1_small_exp_d = s1_small_exp_q;
    s1_small_man_d = s1_small_man_q;
    s1_eff_sub_d   = s1_eff_sub_q;
    s2_valid_d     = s2_valid_q;
    s2_sign_d      = s2_sign_q;
    s2_exp_d       = s2_exp_q;
    s2_big_man_d   = s2_big_man_q;
    s2_small_man_d = s2_small_man_q;
    s2_eff_sub_d   = s2_eff_sub_q;
    out_valid_d    = out_valid_q;
    raw_sign_d     = raw_sign_q;
    raw_exp_d      = raw_exp_q;
    raw_man_d      = raw_man_q;

    // Valid bits always advance (bubbles included); payloads only load on a
    // valid entry so the outputs keep their last result between transfers.
    if (!stall) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_big_d       = a_is_big ? ua : ub;
        s1_small_exp_d = a_is_big ? ub.exponent : ua.exponent;
        s1_small_man_d = a_is_big ? ub.mantissa : ua.mantissa;
        s1_eff_sub_d   = ua.sign ^ ub.sign;
      end

      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d      = s1_big_q.sign;
        s2_exp_d       = s1_big_q.exponent;
        s2_big_man_d   = s1_big_q.mantissa;
        s2_small_man_d = small_aligned;
        s2_eff_sub_d   = s1_eff_sub_q;
      end

      out_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        raw_sign_d = s2_sign_q;
        raw_exp_d  = s2_exp_q;
        raw_man_d  = s2_eff_sub_q ? ({1'b0, s2_big_man_q} - {1'b0, s2_small_man_q})
                                  : ({1'b0, s2_big_man_q} + {1'b0, s2_small_man_q});
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q     <= 1'b0;
      s1_big_q       <= '0;
      s1_small_exp_q <= '0;
      s1_small_man_q <= '0;
      s1_eff_sub_q   <= 1'b0;
      s2_valid_q     <= 1'b0;
      s2_sign_q      <= 1'b0;
      s2_exp_q       <= '0;
      s2_big_man_q   <= '0;
      s2_small_man_q <= '0;
      s2_eff_sub_q   <= 1'b0;
      out_valid_q    <= 1'b0;
      raw_sign_q     <= 1'b0;
      raw_exp_q      <= '0;
      raw_man_q      <= '0;
    end else begin
      s1_valid_q     <= s1_valid_d;
      s1_big_q       <= s1_big_d;
      s1_small_exp_q <= s1_small_exp_d;
      s1_small_man_q <= s1_small_man_d;
      s1_eff_sub_q   <= s1_eff_sub_d;
      s2_valid_q     <= s2_valid_d;
      s2_sign_q      <= s2_sign_d;
      s2_exp_q       <= s2_exp_d;
      s2_big_man_q   <= s2_big_man_d;
      s2_small_man_q <= s2_small_man_d;
      s2_eff_sub_q   <= s2_eff_sub_d;
      out_valid_q    <= out_valid_d;
      raw_sign_q     <= raw_sign_d;
      raw_exp_q      <= raw_exp_d;
      raw_man_q      <= raw_man_d;
    end
  end

endmodule
